// File: rtl/ahb_lite_splitter_if.sv
// ahb_lite_splitter_if: master-side AHB-Lite signals plus the fanned-out per-slave select/ready/response/data.
interface ahb_lite_splitter_if #(parameter int NUM_SLAVES = 8);
  logic [31:0] HADDR;
  logic [1:0] HTRANS;
  logic HREADY, HRESP, BUSERR_IRQ;
  logic [31:0] HRDATA;
  logic [NUM_SLAVES-1:0] HSEL_S, HREADYOUT_S, HRESP_S;
  logic [32*NUM_SLAVES-1:0] HRDATA_S;
  modport slave (input HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
                 output HREADY, HRESP, HRDATA, HSEL_S, BUSERR_IRQ);
  modport master (output HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
                  input HREADY, HRESP, HRDATA, HSEL_S, BUSERR_IRQ);
endinterface

// File: rtl/ahb_lite_splitter.sv
// ahb_lite_splitter: AHB-Lite address decoder/response mux with a two-cycle ERROR default slave.
// Define AHB_SPLIT_TIMEOUT_EN to add a wait-state watchdog that converts a stuck slave into an ERROR.
module ahb_lite_splitter #(
  parameter int NUM_SLAVES = 8,
  parameter int SLOT_LSB = 20,
  parameter int SLOT_BITS = 4,
  parameter logic [31:0] BASE_TAG = 32'h40,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic HCLK,
  input logic HRESET,
  ahb_lite_splitter_if.slave bus
);
  localparam int TAG_LSB = SLOT_LSB + SLOT_BITS;
  localparam int IW = $clog2(NUM_SLAVES);
  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;
  state_t state_q, state_d;
  logic [SLOT_BITS-1:0] slot;
  logic [NUM_SLAVES-1:0] sel;
  logic hit, def_acc, hready, hresp, s_ready, s_resp, to_hit, dp_slv_q, dp_slv_d, irq_q;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0] s_rdata;
  logic unused_addr;
  assign slot = bus.HADDR[SLOT_LSB +: SLOT_BITS];
  assign hit = bus.HTRANS[1] && (bus.HADDR >> TAG_LSB) == BASE_TAG && int'(slot) < NUM_SLAVES;
  assign def_acc = bus.HTRANS[1] && !hit;
  assign unused_addr = ^{bus.HADDR[SLOT_LSB-1:0], bus.HTRANS[0]};
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) sel[i] = hit && int'(slot) == i;
  end
  // idle bus (no slave in data phase) reads as a zero-wait OKAY
  always_comb begin
    s_ready = 1'b1;
    s_resp = 1'b0;
    s_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (dp_slv_q && idx_q == IW'(i)) begin
        s_ready = bus.HREADYOUT_S[i];
        s_resp = bus.HRESP_S[i];
        s_rdata = bus.HRDATA_S[32*i +: 32];
      end
  end
`ifdef AHB_SPLIT_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic wait_s;
  assign wait_s = dp_slv_q && !s_ready;
  assign to_hit = wait_s && cnt_q == 32'(TIMEOUT_CYCLES - 1);
  assign cnt_d = (wait_s && !to_hit) ? cnt_q + 32'd1 : '0;
  always_ff @(posedge HCLK) cnt_q <= HRESET ? '0 : cnt_d;
`else
  assign to_hit = 1'b0;
`endif
  always_ff @(posedge HCLK) state_q <= HRESET ? IDLE : state_d;
  always_comb state_d = state_q == ERR1 ? ERR2 : (to_hit || (hready && def_acc)) ? ERR1 : IDLE;
  always_comb begin
    hready = state_q == ERR1 ? 1'b0 : state_q == ERR2 ? 1'b1 : s_ready;
    hresp = state_q != IDLE || s_resp;
  end
  assign dp_slv_d = to_hit ? 1'b0 : hready ? hit : dp_slv_q;
  assign idx_d = hready ? IW'(slot) : idx_q;
  always_ff @(posedge HCLK)
    if (HRESET) begin
      dp_slv_q <= 1'b0;
      idx_q <= '0;
      irq_q <= 1'b0;
    end else begin
      dp_slv_q <= dp_slv_d;
      idx_q <= idx_d;
      irq_q <= hready && hresp;
    end
  assign bus.HSEL_S = sel;
  assign bus.HREADY = hready;
  assign bus.HRESP = hresp;
  assign bus.HRDATA = s_rdata;
  assign bus.BUSERR_IRQ = irq_q;
endmodule
